umi_target_regbank: RTL and testbench
=====================================

Name: umi_target_regbank

Overview:
- UMI responder (target) for the JTAG-driven UMI initiator: decodes UMI requests and executes them against a local register bank.
- Returns umi_rdata / umi_ack / umi_retry / umi_err.
- Sits on the user side of the debug path, so host software can read and write control/status registers in user logic.
- The local side gets a read port, a write-strobe notification and a busy input.

Parameters:
- ADDR_W, 4: register index width; bank holds 2**ADDR_W registers of 36 bits.
- BASE, 12'h000: required value of umi_addr[17:ADDR_W+2] for a hit. Its width is 16-ADDR_W; the default of 12 bits matches ADDR_W=4.
- WAIT_CYC, 2: wait states between request capture and ack; range 0..15.

Ports:
- umi_clk  in  1  clock.
- rstn  in  1  reset.
- umi_addr  in  18  byte address; [1:0] is the lane, [ADDR_W+1:2] is the register index.
- umi_wdata  in  36  write data.
- umi_size  in  2  transfer size: 00 byte, 01 half, 10 word, 11 full 36-bit.
- umi_wr_n  in  1  0 = write, 1 = read.
- umi_burst  in  1  burst request; not supported.
- umi_lock  in  1  ignored.
- umi_rdy  in  1  request valid; held with stable fields until ack.
- umi_rdata  out  36  read data, valid in the ack cycle.
- umi_ack  out  1  one-cycle completion pulse.
- umi_retry  out  1  qualifies ack: target busy, no action taken.
- umi_err  out  1  qualifies ack: decode, size or burst error, no action taken.
- loc_busy  in  1  local side forbids access.
- loc_rd_idx  in  ADDR_W  local read index.
- loc_rd_data  out  36  combinational read of bank[loc_rd_idx].
- loc_wr_stb  out  1  one-cycle pulse when a UMI write commits.
- loc_wr_idx  out  ADDR_W  index of the committed write, valid with loc_wr_stb.

Behaviour:
- Reset: rstn asynchronous, active-low; clock umi_clk.
  - All bank entries, umi_rdata, umi_ack, umi_retry, umi_err, loc_wr_stb and loc_wr_idx reset to 0.
  - FSM resets to IDLE.
- FSM states: IDLE, WAIT, RESP, DRAIN.
- IDLE: on umi_rdy=1, capture addr, wdata, size, wr_n and burst; load wait counter with WAIT_CYC; go to WAIT, or directly to RESP if WAIT_CYC=0.
- WAIT: decrement the counter; at 0 go to RESP.
- RESP (one cycle):
  - Drive umi_ack=1.
  - Classification, in priority order:
    - err if burst=1, or addr[17:ADDR_W+2]≠BASE, or misaligned (size 01 with addr[0]=1; size 10 or 11 with addr[1:0]≠0).
    - Otherwise retry if loc_busy=1, sampled in the RESP cycle.
    - Otherwise the access executes.
  - Go to DRAIN.
- Execution rules:
  - Write, size 00: updates byte lane addr[1:0], bits [8*lane+7:8*lane].
  - Write, size 01: updates half lane addr[1], bits [16*h+15:16*h].
  - Write, size 10: updates bits [31:0].
  - Write, size 11: updates all 36 bits.
  - Bits outside the lane are untouched.
  - A committed write pulses loc_wr_stb with loc_wr_idx in the RESP cycle; the bank updates at the end of that cycle.
  - Read returns the full 36-bit entry on umi_rdata, no lane shifting.
- Outside RESP: umi_rdata=0, ack/retry/err=0. On err or retry, umi_rdata=0.
- DRAIN: wait for umi_rdy=0, then go to IDLE. Each request is executed at most once even if the initiator holds rdy high.
- Latency: rdy rising to ack = WAIT_CYC+1 cycles.
- Fields changing while in WAIT are ignored; the captured copy is used.
- umi_rdy dropping during WAIT: the request is aborted; return to IDLE, no ack, no write.
- Simultaneous local read and UMI write of the same index: loc_rd_data shows the old value in the RESP cycle and the new value from the next cycle.
- Reset mid-transaction: FSM returns to IDLE, bank cleared, no ack emitted.

Test Plan:
- Reset, then read idx 3 (addr 18'h0000C, size 11, WAIT_CYC=2) -> ack 3 cycles after rdy; rdata=0; retry=err=0.
- Word write 36'h0_DEADBEEF to addr 18'h00014 (size 10), then full read -> loc_wr_stb with loc_wr_idx=5; read returns 36'h0_DEADBEEF; loc_rd_idx=5 matches.
- Byte write wdata=36'h0_000000A5, size 00, addr 18'h00015 over 36'h0_11223344 -> entry becomes 36'h0_1122A544.
- Decode miss: addr 18'h00100 with BASE=0 -> ack+err, no loc_wr_stb, bank unchanged. Separately, a burst=1 request -> ack+err.
- loc_busy=1 during a write -> ack+retry, no write. Hold rdy high across 5 cycles -> exactly one ack until rdy drops.
- Drop rdy mid-WAIT (WAIT_CYC=4, drop after 2 cycles) -> no ack; the next request completes normally. Assert rstn=0 in WAIT -> all outputs 0, bank cleared.

Source files
------------

// File: rtl/umi_target_regbank.sv
// UMI target register bank: decodes single UMI requests from the debug
// initiator and executes them against a local bank of 36-bit registers.
// The local side gets a combinational read port, a write notification
// and a busy input that turns requests into retries.
module umi_target_regbank #(
    parameter int                 ADDR_W   = 4,
    parameter logic [15-ADDR_W:0] BASE     = 12'h000,
    parameter int                 WAIT_CYC = 2
) (
    input  logic              umi_clk,
    input  logic              rstn,
    input  logic [17:0]       umi_addr,
    input  logic [35:0]       umi_wdata,
    input  logic [1:0]        umi_size,
    input  logic              umi_wr_n,
    input  logic              umi_burst,
    input  logic              umi_lock,
    input  logic              umi_rdy,
    output logic [35:0]       umi_rdata,
    output logic              umi_ack,
    output logic              umi_retry,
    output logic              umi_err,
    input  logic              loc_busy,
    input  logic [ADDR_W-1:0] loc_rd_idx,
    output logic [35:0]       loc_rd_data,
    output logic              loc_wr_stb,
    output logic [ADDR_W-1:0] loc_wr_idx
);

    localparam int NREG = 2**ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt;
    logic [17:0]       cap_addr;
    logic [35:0]       cap_wdata;
    logic [1:0]        cap_size;
    logic              cap_wr_n;
    logic              cap_burst;
    logic [35:0]       bank [NREG];
    logic [ADDR_W-1:0] cap_idx;
    logic [1:0]        cap_lane;
    logic              misalign;
    logic              dec_err;
    logic              commit;
    logic [35:0]       wr_mask;
    logic [35:0]       wr_data;
    logic              unused_lock;

    // Locked transfers carry no meaning for a register target.
    assign unused_lock = umi_lock;

    assign cap_idx  = cap_addr[ADDR_W+1:2];
    assign cap_lane = cap_addr[1:0];
    assign misalign = ((cap_size == 2'b01) && cap_lane[0]) ||
                      (cap_size[1] && (cap_lane != 2'b00));
    assign dec_err  = cap_burst || (cap_addr[17:ADDR_W+2] != BASE) || misalign;

    assign loc_rd_data = bank[loc_rd_idx];

    // State register.
    always_ff @(posedge umi_clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state always uses <= so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Capture the request once in IDLE and count down the wait states.
    always_ff @(posedge umi_clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt  <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_size  <= '0;
            cap_wr_n  <= 1'b1;
            cap_burst <= 1'b0;
        end else if ((state == IDLE) && umi_rdy) begin
            wait_cnt  <= 4'(WAIT_CYC);
            cap_addr  <= umi_addr;
            cap_wdata <= umi_wdata;
            cap_size  <= umi_size;
            cap_wr_n  <= umi_wr_n;
            cap_burst <= umi_burst;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Lane mask and lane-aligned write data for the captured size/address.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        wr_mask = '0;
        wr_data = '0;
        case (cap_size)
            2'b00: begin
                wr_mask = 36'hFF << {cap_lane, 3'b000};
                wr_data = {28'd0, cap_wdata[7:0]} << {cap_lane, 3'b000};
            end
            2'b01: begin
                wr_mask = 36'hFFFF << {cap_lane[1], 4'b0000};
                wr_data = {20'd0, cap_wdata[15:0]} << {cap_lane[1], 4'b0000};
            end
            2'b10: begin
                wr_mask = {4'h0, 32'hFFFF_FFFF};
                wr_data = {4'h0, cap_wdata[31:0]};
            end
            default: begin
                wr_mask = '1;
                wr_data = cap_wdata;
            end
        endcase
    end

    // Next state and response outputs; everything is quiet outside RESP.
    always_comb begin
        state_nxt  = state;
        umi_ack    = 1'b0;
        umi_err    = 1'b0;
        umi_retry  = 1'b0;
        umi_rdata  = '0;
        loc_wr_stb = 1'b0;
        loc_wr_idx = '0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (umi_rdy) state_nxt = (WAIT_CYC == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (!umi_rdy)              state_nxt = IDLE;
                else if (wait_cnt <= 4'd1) state_nxt = RESP;
            end
            RESP: begin
                state_nxt = DRAIN;
                umi_ack   = 1'b1;
                if (dec_err) begin
                    umi_err = 1'b1;
                end else if (loc_busy) begin
                    umi_retry = 1'b1;
                end else if (cap_wr_n) begin
                    umi_rdata = bank[cap_idx];
                end else begin
                    commit     = 1'b1;
                    loc_wr_stb = 1'b1;
                    loc_wr_idx = cap_idx;
                end
            end
            DRAIN: begin
                if (!umi_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register bank: lane-merged update at the end of a committing RESP cycle.
    always_ff @(posedge umi_clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the bank is flops, not a RAM macro, so it can and must clear on reset.
            for (int i = 0; i < NREG; i++) bank[i] <= '0;
        end else if (commit) begin
            bank[cap_idx] <= (bank[cap_idx] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

endmodule

// File: tb/tb_umi_target_regbank.sv
// Self-checking bench for umi_target_regbank: directed cases plus random
// requests checked against a per-bit reference model of the bank.
module tb_umi_target_regbank;

    localparam int ADDR_W   = 4;
    localparam int WAIT_CYC = 2;

    logic              umi_clk = 1'b0;
    logic              rstn = 1'b0;
    logic [17:0]       umi_addr = '0;
    logic [35:0]       umi_wdata = '0;
    logic [1:0]        umi_size = '0;
    logic              umi_wr_n = 1'b1;
    logic              umi_burst = 1'b0;
    logic              umi_lock = 1'b0;
    logic              umi_rdy = 1'b0;
    logic [35:0]       umi_rdata;
    logic              umi_ack;
    logic              umi_retry;
    logic              umi_err;
    logic              loc_busy = 1'b0;
    logic [ADDR_W-1:0] loc_rd_idx = '0;
    logic [35:0]       loc_rd_data;
    logic              loc_wr_stb;
    logic [ADDR_W-1:0] loc_wr_idx;

    int checks = 0;
    int errors = 0;
    logic [35:0] model [16];

    umi_target_regbank #(
        .ADDR_W  (ADDR_W),
        .BASE    (12'h000),
        .WAIT_CYC(WAIT_CYC)
    ) dut (
        .umi_clk    (umi_clk),
        .rstn       (rstn),
        .umi_addr   (umi_addr),
        .umi_wdata  (umi_wdata),
        .umi_size   (umi_size),
        .umi_wr_n   (umi_wr_n),
        .umi_burst  (umi_burst),
        .umi_lock   (umi_lock),
        .umi_rdy    (umi_rdy),
        .umi_rdata  (umi_rdata),
        .umi_ack    (umi_ack),
        .umi_retry  (umi_retry),
        .umi_err    (umi_err),
        .loc_busy   (loc_busy),
        .loc_rd_idx (loc_rd_idx),
        .loc_rd_data(loc_rd_data),
        .loc_wr_stb (loc_wr_stb),
        .loc_wr_idx (loc_wr_idx)
    );

    always #5 umi_clk = ~umi_clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference write: copy the low n bits of the write data into the lane, bit by bit.
    function automatic logic [35:0] merge(input logic [35:0] old, input logic [35:0] d,
                                          input logic [1:0] sz, input logic [1:0] lane);
        int lo;
        int n;
        logic [35:0] r;
        r = old;
        case (sz)
            2'd0:    begin lo = 8 * lane;        n = 8;  end
            2'd1:    begin lo = 16 * (lane / 2); n = 16; end
            2'd2:    begin lo = 0;               n = 32; end
            default: begin lo = 0;               n = 36; end
        endcase
        for (int b = 0; b < n; b++) r[lo + b] = d[b];
        return r;
    endfunction

    task automatic umi_req(input logic [17:0] a, input logic [35:0] d, input logic [1:0] sz,
                           input logic wr_n, input logic burst, input logic busy,
                           input int hold, input bit scramble, input string tag);
        int          idx;
        int          n;
        bit          seen;
        bit          exp_err;
        bit          exp_retry;
        bit          exp_stb;
        logic [35:0] exp_rdata;
        logic [35:0] old;
        idx       = int'(a[5:2]);
        exp_err   = burst || (a[17:6] != 12'd0) || ((sz == 2'd1) && (a % 2 != 0)) ||
                    ((sz >= 2'd2) && (a % 4 != 0));
        exp_retry = !exp_err && busy;
        exp_stb   = !exp_err && !busy && !wr_n;
        old       = model[idx];
        exp_rdata = (!exp_err && !busy && wr_n) ? old : 36'd0;

        @(posedge umi_clk); #1;
        umi_addr   = a;
        umi_wdata  = d;
        umi_size   = sz;
        umi_wr_n   = wr_n;
        umi_burst  = burst;
        loc_busy   = busy;
        loc_rd_idx = idx[ADDR_W-1:0];
        umi_rdy    = 1'b1;

        seen = 0;
        n    = 0;
        while (!seen && n < 20) begin
            @(negedge umi_clk);
            n++;
            if (umi_ack) seen = 1;
            else if (scramble && n == 2) begin
                umi_addr  = 18'($urandom);
                umi_wdata = {4'($urandom), $urandom};
                umi_size  = 2'($urandom);
                umi_wr_n  = 1'($urandom);
                umi_burst = 1'($urandom);
            end
        end
        check({tag, "_ack"}, 64'(seen), 64'd1);
        // n counts the cycle in which rdy rose as 1.
        check({tag, "_latency"}, 64'(n - 1), 64'(WAIT_CYC + 1));
        check({tag, "_err"}, 64'(umi_err), 64'(exp_err));
        check({tag, "_retry"}, 64'(umi_retry), 64'(exp_retry));
        check({tag, "_rdata"}, 64'(umi_rdata), 64'(exp_rdata));
        check({tag, "_stb"}, 64'(loc_wr_stb), 64'(exp_stb));
        if (exp_stb) check({tag, "_stb_idx"}, 64'(loc_wr_idx), 64'(idx));
        check({tag, "_rd_old"}, 64'(loc_rd_data), 64'(old));
        if (exp_stb) model[idx] = merge(old, d, sz, a[1:0]);

        for (int h = 0; h < hold; h++) begin
            @(negedge umi_clk);
            check({tag, "_hold_noack"}, 64'(umi_ack), 64'd0);
        end
        @(posedge umi_clk); #1;
        umi_rdy  = 1'b0;
        loc_busy = 1'b0;
        @(negedge umi_clk);
        check({tag, "_post_noack"}, 64'(umi_ack), 64'd0);
        check({tag, "_rd_new"}, 64'(loc_rd_data), 64'(model[idx]));
    endtask

    // Raise rdy for one cycle into WAIT and withdraw it: nothing may happen.
    task automatic umi_abort(input logic [17:0] a, input logic [35:0] d, input string tag);
        bit any_ack;
        bit any_stb;
        @(posedge umi_clk); #1;
        umi_addr   = a;
        umi_wdata  = d;
        umi_size   = 2'd3;
        umi_wr_n   = 1'b0;
        umi_burst  = 1'b0;
        loc_rd_idx = a[5:2];
        umi_rdy    = 1'b1;
        @(posedge umi_clk); #1;
        umi_rdy = 1'b0;
        any_ack = 0;
        any_stb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge umi_clk);
            if (umi_ack) any_ack = 1;
            if (loc_wr_stb) any_stb = 1;
        end
        check({tag, "_noack"}, 64'(any_ack), 64'd0);
        check({tag, "_nostb"}, 64'(any_stb), 64'd0);
        check({tag, "_bank"}, 64'(loc_rd_data), 64'(model[int'(a[5:2])]));
    endtask

    initial begin
        logic [17:0] a;
        logic [1:0]  sz;
        bit          any_ack;

        for (int i = 0; i < 16; i++) model[i] = '0;
        repeat (3) @(posedge umi_clk);
        @(negedge umi_clk);
        check("rst_ack", 64'(umi_ack), 64'd0);
        check("rst_retry", 64'(umi_retry), 64'd0);
        check("rst_err", 64'(umi_err), 64'd0);
        check("rst_rdata", 64'(umi_rdata), 64'd0);
        check("rst_stb", 64'(loc_wr_stb), 64'd0);
        check("rst_stb_idx", 64'(loc_wr_idx), 64'd0);
        check("rst_bank0", 64'(loc_rd_data), 64'd0);
        @(posedge umi_clk); #1;
        rstn = 1'b1;

        umi_req(18'h0000C, 36'h0, 2'b11, 1'b1, 1'b0, 1'b0, 0, 0, "rd3");
        umi_req(18'h00014, 36'h0_DEADBEEF, 2'b10, 1'b0, 1'b0, 1'b0, 0, 0, "wr5");
        umi_req(18'h00014, 36'h0, 2'b11, 1'b1, 1'b0, 1'b0, 0, 0, "rd5");
        check("rd5_const", 64'(loc_rd_data), 64'h0_DEADBEEF);
        umi_req(18'h00014, 36'h0_11223344, 2'b10, 1'b0, 1'b0, 1'b0, 0, 0, "wr5b");
        umi_req(18'h00015, 36'h0_000000A5, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, "byte");
        check("byte_const", 64'(loc_rd_data), 64'h0_1122A544);
        umi_req(18'h0001A, 36'h9_0000BEEF, 2'b01, 1'b0, 1'b0, 1'b0, 0, 0, "half");
        umi_req(18'h00018, 36'hF_FFFFFFFF, 2'b11, 1'b0, 1'b0, 1'b0, 0, 0, "full");
        umi_req(18'h00100, 36'h1_23456789, 2'b11, 1'b0, 1'b0, 1'b0, 0, 0, "miss");
        umi_req(18'h00014, 36'h0, 2'b11, 1'b1, 1'b1, 1'b0, 0, 0, "burst");
        umi_req(18'h00011, 36'h0_0000FFFF, 2'b01, 1'b0, 1'b0, 1'b0, 0, 0, "mis_half");
        umi_req(18'h00016, 36'hF_FFFFFFFF, 2'b11, 1'b0, 1'b0, 1'b0, 0, 0, "mis_full");
        umi_req(18'h00014, 36'h5_55555555, 2'b11, 1'b0, 1'b0, 1'b1, 0, 0, "busy");
        umi_req(18'h00014, 36'h0, 2'b11, 1'b1, 1'b0, 1'b0, 5, 0, "hold");
        umi_req(18'h0001C, 36'h0_CAFEF00D, 2'b10, 1'b0, 1'b0, 1'b0, 1, 1, "scramble");
        umi_abort(18'h00020, 36'hA_AAAAAAAA, "abort");
        umi_req(18'h00020, 36'h3_0000CAFE, 2'b11, 1'b0, 1'b0, 1'b0, 0, 0, "after_abort");

        for (int t = 0; t < 60; t++) begin
            a  = {12'h000, 4'($urandom), 2'($urandom)};
            sz = 2'($urandom);
            if ($urandom_range(0, 7) == 0) a[17:6] = 12'($urandom_range(1, 4095));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1)  a[0]   = 1'b0;
                else if (sz[1])  a[1:0] = 2'b00;
            end
            umi_req(a, {4'($urandom), $urandom}, sz, ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
                    $urandom_range(0, 2), 1'($urandom), "rnd");
        end

        // Reset while a write sits in WAIT.
        umi_req(18'h0001C, 36'h7_77777777, 2'b11, 1'b0, 1'b0, 1'b0, 0, 0, "pre_rst");
        @(posedge umi_clk); #1;
        umi_addr   = 18'h0001C;
        umi_wdata  = 36'h1_11111111;
        umi_size   = 2'b11;
        umi_wr_n   = 1'b0;
        umi_burst  = 1'b0;
        umi_rdy    = 1'b1;
        @(posedge umi_clk); #1;
        rstn = 1'b0;
        #1;
        check("mid_rst_ack", 64'(umi_ack), 64'd0);
        check("mid_rst_rdata", 64'(umi_rdata), 64'd0);
        check("mid_rst_stb", 64'(loc_wr_stb), 64'd0);
        for (int i = 0; i < 16; i++) begin
            model[i]   = '0;
            loc_rd_idx = 4'(i);
            #1;
            check("mid_rst_bank", 64'(loc_rd_data), 64'd0);
        end
        @(posedge umi_clk); #1;
        umi_rdy = 1'b0;
        rstn    = 1'b1;
        any_ack = 0;
        repeat (4) begin
            @(negedge umi_clk);
            if (umi_ack) any_ack = 1;
        end
        check("post_rst_noack", 64'(any_ack), 64'd0);
        umi_req(18'h0001C, 36'h0, 2'b11, 1'b1, 1'b0, 1'b0, 0, 0, "post_rst_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
